// File: rtl/au_prefix_op_pipe.sv
// Purpose : pipelined Kogge-Stone prefix scan, po[i] = pi[0] OP ... OP pi[i], OP = AND/OR/XOR.
// Latency : PIPE+1 cycles from acceptance to po when not stalled; one word per cycle.
// Backpr. : valid/ready per stage with bubble collapse; holds up to PIPE+1 words while out_ready=0.
//
// Ports   : clk, rst_n (async active-low); in_valid/in_ready/pi upstream handshake and data;
//           out_valid/out_ready/po downstream handshake and registered result.
// Option  : define AU_PREFIX_OP_PIPE_TAG_EN to add tag_i/tag_o, a TAG_W sideband that
//           travels with each word through every stage.
module au_prefix_op_pipe #(
    parameter int WIDTH = 8,
    parameter int OP    = 0,
    parameter int PIPE  = 0,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] po
`ifdef AU_PREFIX_OP_PIPE_TAG_EN
    ,
    input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0] tag_o
`endif
);

    localparam int M  = $clog2(WIDTH);
    localparam int NS = PIPE + 1;

    // Elaboration-time parameter checks.
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "au_prefix_op_pipe: illegal parameter WIDTH=%0d", WIDTH);
    end
    if (OP < 0 || OP > 2) begin : g_bad_op
        $fatal(1, "au_prefix_op_pipe: illegal parameter OP=%0d", OP);
    end
    if (PIPE < 0 || PIPE > M) begin : g_bad_pipe
        $fatal(1, "au_prefix_op_pipe: illegal parameter PIPE=%0d", PIPE);
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $fatal(1, "au_prefix_op_pipe: illegal parameter TAG_W=%0d", TAG_W);
    end

    function automatic logic op_fn(input logic a, input logic b);
        logic r;
        case (OP)
            0:       r = a & b;
            1:       r = a | b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // Applies Kogge-Stone levels lo+1..hi (distance 2^(l-1) at level l) to x.
    function automatic logic [WIDTH-1:0] scan_levels(input logic [WIDTH-1:0] x,
                                                     input int lo, input int hi);
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;
        cur = x;
        for (int l = 1; l <= M; l++) begin
            nxt = cur;
            if (l > lo && l <= hi) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (i >= (1 << (l - 1))) begin
                        nxt[i] = op_fn(cur[i], cur[i - (1 << (l - 1))]);
                    end
                end
            end
            cur = nxt;
        end
        return cur;
    endfunction

    logic [WIDTH-1:0] stg_dat [NS];
    logic [WIDTH-1:0] stg_nxt [NS];
    logic [NS-1:0]    stg_vld;
    logic [NS-1:0]    stg_ld;
    logic [NS-1:0]    up_vld;
    logic             load_chain;

    // Stage j owns levels (ceil(j*M/NS), ceil((j+1)*M/NS)]; the last stage ends at level M.
    for (genvar j = 0; j < NS; j++) begin : g_stage
        localparam int LO = (j * M + PIPE) / NS;
        localparam int HI = ((j + 1) * M + PIPE) / NS;
        if (j == 0) begin : g_head
            assign stg_nxt[j] = scan_levels(pi, LO, HI);
            assign up_vld[j]  = in_valid;
        end else begin : g_body
            assign stg_nxt[j] = scan_levels(stg_dat[j-1], LO, HI);
            assign up_vld[j]  = stg_vld[j-1];
        end
    end

    // A stage loads when it is empty or its contents move on; walked from the output back.
    always_comb begin
        stg_ld     = '0;
        load_chain = out_ready;
        for (int k = NS - 1; k >= 0; k--) begin
            stg_ld[k]  = !stg_vld[k] || load_chain;
            load_chain = stg_ld[k];
        end
    end

    assign in_ready  = stg_ld[0];
    assign out_valid = stg_vld[NS-1];
    assign po        = stg_dat[NS-1];

    // Data only updates when a real word arrives, so po holds its last value through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld <= '0;
            for (int k = 0; k < NS; k++) begin
                stg_dat[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (stg_ld[k]) begin
                    stg_vld[k] <= up_vld[k];
                    if (up_vld[k]) begin
                        stg_dat[k] <= stg_nxt[k];
                    end
                end
            end
        end
    end

`ifdef AU_PREFIX_OP_PIPE_TAG_EN
    logic [TAG_W-1:0] stg_tag [NS];
    logic [TAG_W-1:0] up_tag  [NS];

    for (genvar j = 0; j < NS; j++) begin : g_tag_src
        if (j == 0) begin : g_head
            assign up_tag[j] = tag_i;
        end else begin : g_body
            assign up_tag[j] = stg_tag[j-1];
        end
    end

    // Same enables as the data path keep each tag aligned with its word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) begin
                stg_tag[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (stg_ld[k] && up_vld[k]) begin
                    stg_tag[k] <= up_tag[k];
                end
            end
        end
    end

    assign tag_o = stg_tag[NS-1];
`endif

endmodule

// File: tb/tb_au_prefix_op_pipe.sv
// Bench for au_prefix_op_pipe: three instances (A: W8 OR PIPE2, B: W8 AND PIPE0, C: W16 XOR PIPE1)
// share handshake inputs; directed table, corner-case sequences, then random traffic against
// a serial-scan reference model with per-instance scoreboards.
module tb_au_prefix_op_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] pi16 = '0;
    logic [2:0]  in_rdy;
    logic [2:0]  out_vld;
    logic [7:0]  po_a;
    logic [7:0]  po_b;
    logic [15:0] po_c;
    logic [15:0] po_w [3];

    int checks = 0;
    int errors = 0;

    int pipe_of [3] = '{2, 0, 1};
    int op_of   [3] = '{1, 0, 2};
    int w_of    [3] = '{8, 8, 16};

    logic [15:0] sb [3][64];
    int          rd [3];
    int          wr [3];
    int          cnt [3];
    logic        stalled [3];
    logic [15:0] held [3];

`ifdef AU_PREFIX_OP_PIPE_TAG_EN
    logic [3:0] tag_in = '0;
    logic [3:0] tag_a;
    logic [3:0] tag_b;
    logic [3:0] tag_c;
`endif

    always #5 clk = ~clk;

    au_prefix_op_pipe #(.WIDTH(8), .OP(1), .PIPE(2), .TAG_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]), .pi(pi16[7:0]),
        .out_valid(out_vld[0]), .out_ready(out_ready), .po(po_a)
`ifdef AU_PREFIX_OP_PIPE_TAG_EN
        , .tag_i(tag_in), .tag_o(tag_a)
`endif
    );

    au_prefix_op_pipe #(.WIDTH(8), .OP(0), .PIPE(0), .TAG_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]), .pi(pi16[7:0]),
        .out_valid(out_vld[1]), .out_ready(out_ready), .po(po_b)
`ifdef AU_PREFIX_OP_PIPE_TAG_EN
        , .tag_i(tag_in), .tag_o(tag_b)
`endif
    );

    au_prefix_op_pipe #(.WIDTH(16), .OP(2), .PIPE(1), .TAG_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]), .pi(pi16),
        .out_valid(out_vld[2]), .out_ready(out_ready), .po(po_c)
`ifdef AU_PREFIX_OP_PIPE_TAG_EN
        , .tag_i(tag_in), .tag_o(tag_c)
`endif
    );

    assign po_w[0] = {8'h00, po_a};
    assign po_w[1] = {8'h00, po_b};
    assign po_w[2] = po_c;

    typedef struct {
        logic [15:0] pi;
        logic [7:0]  exp_a;   // OR scan of pi[7:0]
        logic [7:0]  exp_b;   // AND scan of pi[7:0]
        logic [15:0] exp_c;   // XOR scan of pi[15:0]
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Serial left-to-right accumulation: bit i is the operator folded over pi[0..i].
    function automatic logic [15:0] ref_scan(input logic [15:0] x, input int op, input int w);
        logic [15:0] r;
        logic        acc;
        r      = '0;
        acc    = x[0];
        r[0]   = acc;
        for (int i = 1; i < w; i++) begin
            case (op)
                0:       acc = acc & x[i];
                1:       acc = acc | x[i];
                default: acc = acc ^ x[i];
            endcase
            r[i] = acc;
        end
        return r;
    endfunction

    // Single word, out_ready high: B valid right after acceptance edge, C one later, A two later.
    task automatic send_one(input logic [15:0] p, input logic [7:0] ea, input logic [7:0] eb,
                            input logic [15:0] ec);
        @(negedge clk);
        pi16 = p; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("B vld lat1", {15'd0, out_vld[1]}, 16'd1);
        chk("B po", po_w[1], {8'h00, eb});
        chk("C vld early", {15'd0, out_vld[2]}, 16'd0);
        chk("A vld early", {15'd0, out_vld[0]}, 16'd0);
        @(negedge clk);
        chk("C vld lat2", {15'd0, out_vld[2]}, 16'd1);
        chk("C po", po_w[2], ec);
        chk("A vld early2", {15'd0, out_vld[0]}, 16'd0);
        chk("B vld cleared", {15'd0, out_vld[1]}, 16'd0);
        @(negedge clk);
        chk("A vld lat3", {15'd0, out_vld[0]}, 16'd1);
        chk("A po", po_w[0], {8'h00, ea});
    endtask

    // One random-traffic cycle checked against the scoreboard model of every instance.
    task automatic cycle_chk(input logic iv, input logic orr, input logic [15:0] p);
        @(negedge clk);
        in_valid = iv; out_ready = orr; pi16 = p;
        #1;
        for (int i = 0; i < 3; i++) begin
            logic [15:0] pm;
            logic        exp_rdy;
            pm      = (i == 2) ? p : {8'h00, p[7:0]};
            exp_rdy = (cnt[i] < pipe_of[i] + 1) || orr;
            if (stalled[i]) begin
                chk($sformatf("inst%0d stall vld", i), {15'd0, out_vld[i]}, 16'd1);
                chk($sformatf("inst%0d stall po", i), po_w[i], held[i]);
            end
            chk($sformatf("inst%0d in_ready", i), {15'd0, in_rdy[i]}, {15'd0, exp_rdy});
            if (out_vld[i] && orr) begin
                if (cnt[i] == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst%0d spurious out: got po %h with 0 words expected", i, po_w[i]);
                end else begin
                    chk($sformatf("inst%0d order po", i), po_w[i], sb[i][rd[i]]);
                    rd[i]  = (rd[i] + 1) % 64;
                    cnt[i] = cnt[i] - 1;
                end
            end
            if (iv && in_rdy[i]) begin
                sb[i][wr[i]] = ref_scan(pm, op_of[i], w_of[i]);
                wr[i]        = (wr[i] + 1) % 64;
                cnt[i]       = cnt[i] + 1;
            end
            stalled[i] = out_vld[i] && !orr;
            held[i]    = po_w[i];
        end
    endtask

    initial begin
        int          acc;
        int          n;
        logic [7:0]  got [8];

        tbl[0] = '{16'h00EF, 8'hFF, 8'h0F, 16'hFFA5};
        tbl[1] = '{16'h0010, 8'hF0, 8'h00, 16'hFFF0};
        tbl[2] = '{16'h0001, 8'hFF, 8'h01, 16'hFFFF};
        tbl[3] = '{16'h0003, 8'hFF, 8'h03, 16'h0001};
        tbl[4] = '{16'h0081, 8'hFF, 8'h01, 16'h007F};
        tbl[5] = '{16'h00FF, 8'hFF, 8'hFF, 16'h0055};
        tbl[6] = '{16'h0000, 8'h00, 8'h00, 16'h0000};
        tbl[7] = '{16'h8000, 8'h00, 8'h00, 16'h8000};

        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst inst%0d out_valid", i), {15'd0, out_vld[i]}, 16'd0);
            chk($sformatf("rst inst%0d po", i), po_w[i], 16'd0);
            chk($sformatf("rst inst%0d in_ready", i), {15'd0, in_rdy[i]}, 16'd1);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single words.
        for (int t = 0; t < 8; t++) begin
            send_one(tbl[t].pi, tbl[t].exp_a, tbl[t].exp_b, tbl[t].exp_c);
        end

        // Back-to-back on A (OR, PIPE=2): 10,00,81 -> F0,00,FF on consecutive cycles.
        @(negedge clk); pi16 = 16'h0010; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); pi16 = 16'h0000;
        @(negedge clk); pi16 = 16'h0081;
        @(negedge clk); in_valid = 1'b0;
        chk("b2b A vld0", {15'd0, out_vld[0]}, 16'd1);
        chk("b2b A po0", po_w[0], 16'h00F0);
        @(negedge clk);
        chk("b2b A vld1", {15'd0, out_vld[0]}, 16'd1);
        chk("b2b A po1", po_w[0], 16'h0000);
        @(negedge clk);
        chk("b2b A vld2", {15'd0, out_vld[0]}, 16'd1);
        chk("b2b A po2", po_w[0], 16'h00FF);
        @(negedge clk);
        chk("b2b A vld end", {15'd0, out_vld[0]}, 16'd0);

        // Fill A while stalled: exactly 3 accepted, po stable while stalled.
        pi16 = 16'h0001; in_valid = 1'b1; out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            logic took;
            #1;
            took = in_rdy[0];
            if (took) acc++;
            if (out_vld[0]) chk("stall A po hold", po_w[0], 16'h00FF);
            @(negedge clk);
            if (took) pi16 = pi16 + 16'd1;
        end
        chk("stall A accepted", 16'(acc), 16'd3);
        chk("stall A in_ready", {15'd0, in_rdy[0]}, 16'd0);
        chk("stall A out_valid", {15'd0, out_vld[0]}, 16'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_vld[0] && n < 8) begin
                got[n] = po_a;
                n++;
            end
            @(negedge clk);
        end
        chk("drain A count", 16'(n), 16'd3);
        if (n >= 3) begin
            chk("drain A w0", {8'h00, got[0]}, 16'h00FF);
            chk("drain A w1", {8'h00, got[1]}, 16'h00FE);
            chk("drain A w2", {8'h00, got[2]}, 16'h00FF);
        end

        // Asynchronous reset with two words in flight in A.
        pi16 = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); pi16 = 16'h0002;
        @(negedge clk); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst inst%0d out_valid", i), {15'd0, out_vld[i]}, 16'd0);
            chk($sformatf("midrst inst%0d po", i), po_w[i], 16'd0);
            chk($sformatf("midrst inst%0d in_ready", i), {15'd0, in_rdy[i]}, 16'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_one(16'h00FF, 8'hFF, 8'hFF, 16'h0055);

`ifdef AU_PREFIX_OP_PIPE_TAG_EN
        // Tags on C (PIPE=1) with a stall between the two words.
        @(negedge clk); pi16 = 16'h0001; tag_in = 4'hA; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("tag C vld", {15'd0, out_vld[2]}, 16'd1);
        chk("tag C po0", po_w[2], 16'hFFFF);
        chk("tag C tag0", {12'd0, tag_c}, 16'h000A);
        pi16 = 16'h0003; tag_in = 4'h5; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk("tag C hold", {12'd0, tag_c}, 16'h000A);
        out_ready = 1'b1;
        @(negedge clk);
        chk("tag C po1", po_w[2], 16'h0001);
        chk("tag C tag1", {12'd0, tag_c}, 16'h0005);
        tag_in = 4'h0;
        for (int c = 0; c < 6; c++) @(negedge clk);
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 3; i++) begin
            rd[i] = 0; wr[i] = 0; cnt[i] = 0; stalled[i] = 1'b0; held[i] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            cycle_chk(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 16'($urandom));
        end
        for (int c = 0; c < 8; c++) begin
            cycle_chk(1'b0, 1'b1, 16'h0000);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("inst%0d leftover words", i), 16'(cnt[i]), 16'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/au_prefix_op_pipe.md
Name: au_prefix_op_pipe

Overview:
- Pipelined, parametrised prefix-scan unit for propagate/generate style signal pairs used across the arithmetic units.
- Computes po[i] = pi[0] OP pi[1] OP ... OP pi[i], selectable OP = AND / OR / XOR.
- Configurable number of internal register stages, with valid/ready flow control on both sides.
- Sits between operand-conditioning logic and the carry/sticky/parity consumers in multi-cycle adders, comparators and normalisers.

Parameters:
- WIDTH, 8, input/output word length (>= 1).
- OP, 0, scan operator: 0 = AND, 1 = OR, 2 = XOR.
- PIPE, 0, number of internal register stages (0 to M, where M = ceil(log2(WIDTH)); M = 0 when WIDTH = 1).
- TAG_W, 4, sideband tag width (>= 1); only used when the optional feature is compiled in.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  unit can accept input this cycle
- pi  input  WIDTH  scan input vector
- out_valid  output  1  po holds a valid result
- out_ready  input  1  downstream accepts po this cycle
- po  output  WIDTH  prefix-scan result

Behaviour:
- Scan structure: M Kogge-Stone levels.
  - Level l (1..M), distance d = 2^(l-1): x_l[i] = x_{l-1}[i] OP x_{l-1}[i-d] for i >= d; otherwise x_l[i] = x_{l-1}[i].
- Register stages: PIPE+1 stages S1..S(PIPE+1). S(PIPE+1) is always the output register driving po/out_valid.
  - Internal stage Sk (k = 1..PIPE) captures after level ceil(k*M/(PIPE+1)).
- Latency: an accepted word appears on po exactly PIPE+1 cycles after acceptance when no stall occurs.
- Throughput: one word per cycle when out_ready is held high.
- Each stage has a valid bit vk. Stage k loads from upstream when (!vk || stage k+1 loads), with the last stage's "next load" = out_ready.
  - in_ready = !v1 || S1 loads.
  - Input acceptance: in_valid && in_ready.
- Bubble collapse: an empty stage loads even while downstream is stalled.
  - Consequence: a pipeline of PIPE+1 stages holds up to PIPE+1 words while out_ready = 0.
- in_ready is combinational from out_ready and the vk bits; there is no combinational path from pi to po.
- Stall: with out_valid = 1 and out_ready = 0, po and out_valid hold stable. No word is dropped or duplicated.
- When a stage does not load, its data register holds its value. Data of invalid stages is don't-care internally, but po is registered and holds its last value.
- pi is ignored when in_valid = 0; an invalid stage never produces out_valid.
- Reset (asynchronous assert, any time including mid-transfer): all vk = 0, all data registers = 0.
  - Result: out_valid = 0, po = 0, in_ready = 1 after reset.
  - In-flight words are discarded.
  - Deassertion is synchronised externally; the first acceptance is possible at the first rising edge with rst_n = 1.
- WIDTH = 1: po[0] = pi[0] for any OP; the structure is PIPE+1 pure register stages (PIPE must be 0).
- Illegal parameters (WIDTH < 1, OP outside 0..2, PIPE outside 0..M, TAG_W < 1): simulation prints an error naming the parameter and finishes. Synthesis behaviour is undefined.

Optional Feature:
- Macro AU_PREFIX_OP_PIPE_TAG_EN.
- Defined: adds ports tag_i (input, TAG_W) and tag_o (output, TAG_W).
  - tag_i is captured with pi on acceptance and travels through every stage alongside data.
  - tag_o changes only when po changes and resets to 0.
- Undefined: no tag ports and no tag registers; all other behaviour is identical.

Test Plan:
- WIDTH=8, OP=0, PIPE=0, out_ready=1; pi=8'b1110_1111 -> po=8'b0000_1111 with out_valid=1 one cycle after acceptance.
- WIDTH=8, OP=1, PIPE=2 (M=3); back-to-back pi=8'h10, 8'h00, 8'h81 -> po=8'hF0, 8'h00, 8'hFF on consecutive cycles, first result 3 cycles after the first acceptance.
- WIDTH=16, OP=2, PIPE=1; pi=16'h0001 -> po=16'hFFFF; pi=16'h0003 -> po=16'h0001.
- PIPE=2, out_ready=0, in_valid=1 continuously with pi = 8'h01, 8'h02, ... -> exactly 3 words accepted, then in_ready=0.
  - After that, out_ready=1 -> outputs are drained in order with no loss or duplication, and po is stable while stalled.
- Assert rst_n=0 with 2 words in flight -> out_valid=0, po=0, in_ready=1 immediately.
  - Release reset, send pi=8'hFF with OP=0 -> po=8'hFF after PIPE+1 cycles.
- TAG_EN defined, PIPE=1: send tags 4'hA, 4'h5 with a stall inserted between them -> tag_o=4'hA then 4'h5, each aligned with its po.
